// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier arbiter.
//   W     : default operand width (product is 2*W, signed)
//   ID_W  : default response tag width (clog2 of the requester count)
//   P_W   : default product width
//   state_e : arbiter sequencing states
package mul_pkg;

    localparam int W    = 16;
    localparam int ID_W = 2;
    localparam int P_W  = 2 * W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// The search starts one position above the last winner and wraps, so the
// most recently served requester has the lowest priority.
//   req_i : request vector, one bit per requester
//   ptr_i : index of the last granted requester
//   gnt_o : one-hot grant (all zero when nothing is requested)
//   idx_o : encoded index of the granted requester
//   any_o : at least one request present
module rr_pick
    import mul_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // i = N lands back on ptr_i itself, so a lone requester still wins.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one iterative signed Booth multiplier core among N_REQ requesters.
// Round-robin grant, operand latching, core start/done sequencing and a
// bypass that answers 0 without touching the core when an operand is zero.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : per-requester handshake, ready is a one-hot pulse
//   req_x / req_y         : packed operands, requester k at [k*W +: W]
//   core_start            : one-cycle start pulse to the core
//   core_x / core_y       : latched operands, stable while the core runs
//   core_done / core_prod : core completion pulse and its product
//   rsp_valid / rsp_ready : response handshake, held until accepted
//   rsp_id / rsp_data     : owning requester and full-width product
module booth_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = mul_pkg::W,
    parameter int ID_W  = mul_pkg::ID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    output logic               core_start,
    output logic [W-1:0]       core_x,
    output logic [W-1:0]       core_y,
    input  logic               core_done,
    input  logic [2*W-1:0]     core_prod,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [2*W-1:0]     rsp_data
);

    import mul_pkg::*;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [W-1:0]      x_q, x_d;
    logic [W-1:0]      y_q, y_d;
    logic [2*W-1:0]    data_q, data_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [W-1:0]      sel_x, sel_y;

    rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign sel_x = req_x[pick_idx*W +: W];
    assign sel_y = req_y[pick_idx*W +: W];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        x_d        = x_q;
        y_d        = y_q;
        data_d     = data_q;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    x_d       = sel_x;
                    y_d       = sel_y;
                    id_d      = pick_idx;
                    rr_d      = pick_idx;
                    // A zero operand makes the product known; skip the core.
                    if (sel_x == '0 || sel_y == '0) begin
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                // core_done is only honoured here, so stray pulses are dropped.
                if (core_done) begin
                    data_d  = core_prod;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= ID_W'(N_REQ - 1);  // requester 0 wins first
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
        end
    end

    assign core_x   = x_q;
    assign core_y   = y_q;
    assign rsp_id   = id_q;
    assign rsp_data = data_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x = '0;
    logic [N*W-1:0] req_y = '0;
    logic           core_start;
    logic [W-1:0]   core_x, core_y;
    logic           core_done = 1'b0;
    logic [2*W-1:0] core_prod = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    // Requester model: operands, valid flags and the last served index.
    int  vx[N];
    int  vy[N];
    bit  vld[N];
    int  rr_last;
    logic [31:0] last_data;
    logic [1:0]  last_id;

    // Behavioural multiplier core with a random latency per operation.
    bit          late_req = 1'b0;
    int          cnt = 0;
    logic [31:0] prod_q = '0;

    booth_mul_arbiter #(.N_REQ(N), .W(W), .ID_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .core_start (core_start),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_done  (core_done),
        .core_prod  (core_prod),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            cnt <= 0;
        end else if (late_req) begin
            core_done <= 1'b1;
            core_prod <= 32'hDEAD_BEEF;
        end else if (core_start) begin
            cnt    <= int'($urandom_range(1, 6));
            prod_q <= 32'(int'($signed(core_x)) * int'($signed(core_y)));
        end else if (cnt == 1) begin
            cnt       <= 0;
            core_done <= 1'b1;
            core_prod <= prod_q;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            req_valid[k]       = vld[k];
            req_x[k*W +: W]    = 16'(vx[k]);
            req_y[k*W +: W]    = 16'(vy[k]);
        end
    endtask

    // Next winner: first valid requester after the last one served, wrapping.
    function automatic int model_pick();
        for (int i = 1; i <= N; i++)
            if (vld[(rr_last + i) % N]) return (rr_last + i) % N;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < N; k++) vld[k] = 1'b0;
        apply();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rr_last = N - 1;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_ready"}, req_ready, 0);
        chk({pfx, "_start"}, core_start, 0);
        chk({pfx, "_cx"}, core_x, 0);
        chk({pfx, "_cy"}, core_y, 0);
        chk({pfx, "_rv"}, rsp_valid, 0);
        chk({pfx, "_id"}, rsp_id, 0);
        chk({pfx, "_data"}, rsp_data, 0);
    endtask

    // One complete transaction for the model's next winner, with bp cycles
    // of response backpressure. Returns just after the response handshake edge.
    task automatic serve(input int bp, input bit drop);
        int exp_id, n, starts;
        bit zero, dprev, got;
        logic [31:0]  exp_d;
        logic [N-1:0] oh;
        exp_id = model_pick();
        if (exp_id < 0) return;
        oh    = N'(1) << exp_id;
        zero  = (vx[exp_id] == 0) || (vy[exp_id] == 0);
        exp_d = 32'(vx[exp_id] * vy[exp_id]);
        apply();
        @(negedge clk);
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(posedge clk); #1; @(negedge clk); n++;
        end
        chk("grant", req_ready, oh);
        if (req_ready != oh) return;
        @(posedge clk); #1;
        rr_last = exp_id;
        if (drop) vld[exp_id] = 1'b0;
        apply();
        rsp_ready = (bp == 0);
        n = 0; starts = 0; dprev = 0; got = 0;
        while (n < 40) begin
            @(negedge clk); n++;
            if (rsp_valid) begin got = 1; break; end
            chk("busy_ready", req_ready, 0);
            if (core_start) starts++;
            dprev = core_done;
            @(posedge clk); #1;
        end
        chk("rsp_valid", rsp_valid, 1);
        if (!got) return;
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_data", rsp_data, exp_d);
        chk("resp_ready", req_ready, 0);
        chk("starts", starts, zero ? 0 : 1);
        if (zero) chk("bypass_lat", n, 1);
        else      chk("done_to_rsp", dprev, 1);
        last_id   = rsp_id;
        last_data = rsp_data;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1; @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, exp_id);
            chk("bp_data", rsp_data, exp_d);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic signed [15:0] s;
        for (int k = 0; k < N; k++) begin vx[k] = 0; vy[k] = 0; vld[k] = 1'b0; end
        rr_last = N - 1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk_quiet("reset");

        // Single request
        vx[0] = 3; vy[0] = -5; vld[0] = 1'b1;
        serve(0, 1'b1);
        chk("single_data", last_data, 32'hFFFF_FFF1);
        chk("single_id", last_id, 0);

        // Contention: all four held, fresh arbitration from reset
        do_reset();
        for (int k = 0; k < N; k++) begin vx[k] = k + 1; vy[k] = 2; vld[k] = 1'b1; end
        for (int t = 0; t < 6; t++) begin
            serve(0, 1'b0);
            chk("cont_order", last_id, t % N);
            chk("cont_data", last_data, 2 * ((t % N) + 1));
        end
        for (int k = 0; k < N; k++) vld[k] = 1'b0;
        apply();

        // Zero bypass
        vx[2] = 0; vy[2] = 1234; vld[2] = 1'b1;
        serve(0, 1'b1);
        chk("zero_id", last_id, 2);

        // Backpressure with a second requester pending
        vx[0] = 7;  vy[0] = 9;  vld[0] = 1'b1;
        vx[1] = -3; vy[1] = 11; vld[1] = 1'b1;
        serve(5, 1'b1);
        serve(0, 1'b1);
        chk("bp_next_id", last_id, 1);

        // Corner operands
        vx[3] = -32768; vy[3] = -32768; vld[3] = 1'b1;
        serve(0, 1'b1);
        chk("corner_mm", last_data, 32'h4000_0000);
        vx[0] = -32768; vy[0] = 32767; vld[0] = 1'b1;
        serve(1, 1'b1);
        chk("corner_mp", last_data, 32'hC000_8000);

        // Randomised traffic
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!vld[k] && $urandom_range(0, 1) == 1) begin
                    s = 16'($urandom);
                    vx[k] = ($urandom_range(0, 7) == 0) ? 0 : int'(s);
                    s = 16'($urandom);
                    vy[k] = ($urandom_range(0, 7) == 0) ? 0 : int'(s);
                    vld[k] = 1'b1;
                end
            end
            if (model_pick() < 0) vld[$urandom_range(0, N - 1)] = 1'b1;
            serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) vld[$urandom_range(0, N - 1)] = 1'b0;
        end
        for (int k = 0; k < N; k++) vld[k] = 1'b0;
        apply();

        // Reset while waiting on the core
        vx[1] = 5; vy[1] = 6; vld[1] = 1'b1;
        apply();
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(posedge clk); #1; @(negedge clk); n++;
        end
        chk("wr_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        vld[1] = 1'b0;
        apply();
        @(negedge clk);
        chk("wr_start", core_start, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rr_last = N - 1;
        @(negedge clk);
        chk_quiet("wr_reset");
        late_req = 1'b1;
        @(posedge clk); #1;
        late_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_rv", rsp_valid, 0);
            chk("late_start", core_start, 0);
        end
        vx[2] = -100; vy[2] = 77; vld[2] = 1'b1;
        serve(0, 1'b1);
        chk("after_rst", last_data, 32'hFFFF_E1EC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
